if_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and fetches each 32-bit instruction as four byte reads over the shared byte-wide memory port.
- Presents a completed instruction (pc, inst) to IF/ID and drives the fetch-busy flag that IF/ID uses to insert bubbles.
- Redirects the PC on a jump from EX, aborting any fetch in flight.

---
 rtl/if_fetch.sv | 135 +++++++++++++
 tb/tb_if_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: owns the PC and assembles each 32-bit instruction from four byte reads (IF_STALL_EN adds stall_i).
// Latency: 5 cycles per instruction with an always-granting memory (4 requests, last byte, present).
// Backpressure: an ungranted request holds its address; with IF_STALL_EN a finished instruction is parked while stall_i=1.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IF_STALL_EN
    input  logic        stall_i,
`endif
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_busy_o
);

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  recv_cnt_q, recv_cnt_d;
    logic        discard_q, discard_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic        stall;
    logic        present_fire;
    logic        issuing;
    logic        granted;
    logic        byte_in;

`ifdef IF_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    // The presentation cycle doubles as the byte-0 request slot of the next PC.
    always_comb begin
        present_fire = (state_q == ST_PRESENT) && !stall;
        issuing      = (state_q == ST_FETCH) || present_fire;
        mem_req_o    = rst && issuing && (issue_cnt_q < 3'd4);
        mem_addr_o   = pc_q + {29'd0, issue_cnt_q};
        granted      = mem_req_o && mem_gnt_i;
        byte_in      = mem_rvalid_i && !discard_q && (state_q == ST_FETCH);
        if_busy_o    = !present_fire;
        if_pc_o      = if_pc_q;
        if_inst_o    = if_inst_q;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issue_cnt_d = issue_cnt_q + {2'd0, granted};
        recv_cnt_d  = recv_cnt_q;
        discard_d   = 1'b0;
        buf_d       = buf_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;

        case (state_q)
            ST_FETCH: begin
                if (byte_in) begin
                    recv_cnt_d = recv_cnt_q + 3'd1;
                    case (recv_cnt_q[1:0])
                        2'd0: buf_d[7:0]   = mem_rdata_i;
                        2'd1: buf_d[15:8]  = mem_rdata_i;
                        2'd2: buf_d[23:16] = mem_rdata_i;
                        default: begin
                            if_inst_d   = {mem_rdata_i, buf_q};
                            if_pc_d     = pc_q;
                            pc_d        = pc_q + 32'd4;
                            issue_cnt_d = 3'd0;
                            recv_cnt_d  = 3'd0;
                            state_d     = ST_PRESENT;
                        end
                    endcase
                end
            end
            ST_PRESENT: begin
                if (present_fire) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // A jump drops any partial or parked instruction; a byte granted now returns stale next cycle.
        if (jump_i) begin
            pc_d        = jump_addr_i;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 3'd0;
            state_d     = ST_FETCH;
            discard_d   = granted;
            if_pc_d     = if_pc_q;
            if_inst_d   = if_inst_q;
        end
    end

    // discard comes out of reset set so a response to a pre-reset request is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            discard_q   <= 1'b1;
            buf_q       <= 24'd0;
            if_pc_q     <= 32'd0;
            if_inst_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            discard_q   <= discard_d;
            buf_q       <= buf_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte-wide memory responder, presentation-order model, directed jump/reset/wrap scenarios.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        mem_gnt_i = 1'b1;
    logic        mem_rvalid_i = 1'b0;
    logic [7:0]  mem_rdata_i = 8'd0;
`ifdef IF_STALL_EN
    logic        stall_i = 1'b0;
`endif
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_busy_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_pres = 0;
    int          n_held = 0;
    int          last_pres_cyc = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] last_pc = 32'd0;
    logic [31:0] prev_addr = 32'd0;
    logic        prev_hold = 1'b0;
    logic        gnt_rand = 1'b0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef IF_STALL_EN
        .stall_i      (stall_i),
`endif
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o),
        .if_busy_o    (if_busy_o)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'hA0;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5C;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: a grant seen in one cycle returns its byte in the next.
    initial begin : mem_model
        logic        acc;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            acc = mem_req_o && mem_gnt_i;
            a   = mem_addr_o;
            @(posedge clk);
            #1;
            mem_rvalid_i = acc;
            mem_rdata_i  = acc ? mem_byte(a) : 8'h00;
            mem_gnt_i    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Model: presentations must follow PC order from reset/jump target, with the memory's word.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            cyc       = 0;
            exp_pc    = RESET_PC;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                n_held++;
                check("req_held", 32'(mem_req_o), 32'd1);
                check("addr_held", mem_addr_o, prev_addr);
            end
            if (!if_busy_o) begin
                check("pres_pc", if_pc_o, exp_pc);
                check("pres_inst", if_inst_o, word_at(exp_pc));
                n_pres++;
                last_pc       = if_pc_o;
                last_pres_cyc = cyc;
                exp_pc        = exp_pc + 32'd4;
            end
            if (jump_i) exp_pc = jump_addr_i;
            prev_hold = mem_req_o && !mem_gnt_i && !jump_i;
            prev_addr = mem_addr_o;
            cyc++;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_pres(input int n, input int budget);
        int target = n_pres + n;
        int k = 0;
        while (n_pres < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("wait_pres_timeout", 32'(n_pres >= target), 32'd1);
    endtask

    task automatic wait_grant(input logic [31:0] addr, input int budget);
        int k = 0;
        bit hit = 1'b0;
        while (!hit && k < budget) begin
            @(negedge clk);
            k++;
            hit = mem_req_o && mem_gnt_i && (mem_addr_o == addr);
        end
        check("wait_grant_timeout", 32'(hit), 32'd1);
    endtask

    task automatic pulse_jump(input logic [31:0] target);
        @(posedge clk);
        #1;
        jump_i      = 1'b1;
        jump_addr_i = target;
        @(posedge clk);
        #1;
        jump_i      = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        check("rst_busy", 32'(if_busy_o), 32'd1);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_pc", if_pc_o, 32'd0);
        check("rst_inst", if_inst_o, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        // Full-rate fetch from reset
        wait_pres(1, 50);
        check("t1_first_cyc", 32'(last_pres_cyc), 32'd5);
        check("t1_first_pc", last_pc, 32'd0);
        check("t1_first_inst", if_inst_o, 32'h00A0_0513);
        wait_pres(1, 50);
        check("t1_second_cyc", 32'(last_pres_cyc), 32'd10);
        check("t1_second_pc", last_pc, 32'd4);

        // Jump while byte 2 of pc=8 is outstanding
        do_reset();
        wait_grant(32'd10, 100);
        pulse_jump(32'h100);
        wait_pres(1, 100);
        check("t2_jump_pc", last_pc, 32'h100);

        // Jump coincident with the 4th byte of pc=4
        do_reset();
        wait_grant(32'd7, 100);
        pulse_jump(32'h240);
        wait_pres(1, 100);
        check("t3_jump_pc", last_pc, 32'h240);

        // Jump during the presentation cycle of pc=0, unaligned target
        do_reset();
        wait_grant(32'd3, 100);
        @(posedge clk);
        pulse_jump(32'h3FE);
        check("t4_pres_stands_pc", last_pc, 32'd0);
        check("t4_pres_stands_cyc", 32'(last_pres_cyc), 32'd5);
        wait_pres(1, 100);
        check("t4_jump_pc", last_pc, 32'h3FE);

        // 32-bit wrap of pc and of byte addresses
        pulse_jump(32'hFFFF_FFF8);
        wait_pres(3, 100);
        check("t5_wrap_pc", last_pc, 32'd0);
        pulse_jump(32'hFFFF_FFFE);
        wait_pres(1, 100);
        check("t5_unaligned_pc", last_pc, 32'hFFFF_FFFE);
        check("t5_unaligned_inst", if_inst_o, 32'h0513_87EA);

        // Random grant gaps
        gnt_rand = 1'b1;
        pulse_jump(32'h40);
        wait_pres(30, 3000);
        gnt_rand = 1'b0;
        check("t6_last_pc", last_pc, 32'hB4);
        check("t6_gaps_seen", 32'(n_held > 0), 32'd1);

        // Asynchronous reset mid-fetch (issue_cnt=2 of pc=4) with a late response
        do_reset();
        wait_pres(1, 50);
        wait_grant(32'd6, 50);
        #2 rst = 1'b0;
        #1;
        check("t7_rst_busy", 32'(if_busy_o), 32'd1);
        check("t7_rst_req", 32'(mem_req_o), 32'd0);
        check("t7_rst_pc", if_pc_o, 32'd0);
        check("t7_rst_inst", if_inst_o, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        wait_pres(1, 50);
        check("t7_first_pc", last_pc, RESET_PC);
        check("t7_first_cyc", 32'(last_pres_cyc), 32'd5);

`ifdef IF_STALL_EN
        // Stall held for 7 cycles from the completing cycle
        do_reset();
        wait_grant(32'd3, 50);
        @(posedge clk);
        #1 stall_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stall_busy", 32'(if_busy_o), 32'd1);
            check("stall_req", 32'(mem_req_o), 32'd0);
        end
        @(posedge clk);
        #1 stall_i = 1'b0;
        @(negedge clk);
        check("stall_release_busy", 32'(if_busy_o), 32'd0);
        check("stall_release_pc", if_pc_o, RESET_PC);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
